// File: rtl/sprite_renderer.sv
// Erase-then-redraw sprite engine driving a VGA pixel-write port.
// Two-stage pixel pipeline shared by the erase and draw passes.
module sprite_renderer #(
  parameter int       SPRITE_W    = 10,
  parameter int       SPRITE_H    = 11,
  parameter int       ADDR_W      = 7,
  parameter logic [2:0] BG_COLOUR   = 3'b011,
  parameter logic [2:0] TRANSPARENT = 3'b111,
  parameter int       SCREEN_W    = 160,
  parameter int       SCREEN_H    = 120
) (
  input  logic              CLOCK,
  input  logic              Reset,
  input  logic [7:0]        vgaX,
  input  logic [6:0]        vgaY,
  output logic [ADDR_W-1:0] romAddr,
  input  logic [2:0]        romData,
  output logic [7:0]        oX,
  output logic [6:0]        oY,
  output logic [2:0]        oColour,
  output logic              oPlot,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(SPRITE_W + 1);
  localparam int RW = $clog2(SPRITE_H + 1);

  typedef enum logic [1:0] {
    IDLE, ERASE, DRAW, FLUSH
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]  new_x_q, new_x_d;
  logic [6:0]  new_y_q, new_y_d;
  logic [7:0]  last_x_q, last_x_d;
  logic [6:0]  last_y_q, last_y_d;
  logic        first_q, first_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        s1_valid_q, s1_valid_d;
  logic        s1_draw_q, s1_draw_d;
  logic        s1_in_q, s1_in_d;
  logic [7:0]  s1_x_q, s1_x_d;
  logic [6:0]  s1_y_q, s1_y_d;

  logic        trigger;
  logic        last_px;
  logic        end_col;
  logic        s0_valid;
  logic        s0_draw;
  logic [7:0]  base_x;
  logic [6:0]  base_y;
  logic [8:0]  px;
  logic [7:0]  py;
  logic [ADDR_W-1:0] rom_addr;

  assign trigger = first_q
                || (vgaX != last_x_q)
                || (vgaY != last_y_q);
  assign end_col = col_q == CW'(SPRITE_W - 1);
  assign last_px = end_col
                && (row_q == RW'(SPRITE_H - 1));

  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      new_x_q    <= '0;
      new_y_q    <= '0;
      last_x_q   <= '0;
      last_y_q   <= '0;
      first_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_draw_q  <= 1'b0;
      s1_in_q    <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      new_x_q    <= new_x_d;
      new_y_q    <= new_y_d;
      last_x_q   <= last_x_d;
      last_y_q   <= last_y_d;
      first_q    <= first_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      s1_valid_q <= s1_valid_d;
      s1_draw_q  <= s1_draw_d;
      s1_in_q    <= s1_in_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    new_x_d  = new_x_q;
    new_y_d  = new_y_q;
    last_x_d = last_x_q;
    last_y_d = last_y_q;
    first_d  = first_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          new_x_d = vgaX;
          new_y_d = vgaY;
          col_d   = '0;
          row_d   = '0;
          busy_d  = 1'b1;
          state_d = first_q ? DRAW : ERASE;
        end
      end
      ERASE, DRAW: begin
        if (last_px) begin
          col_d   = '0;
          row_d   = '0;
          state_d = (state_q == ERASE)
                  ? DRAW : FLUSH;
        end else if (end_col) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      FLUSH: begin
        last_x_d = new_x_q;
        last_y_d = new_y_q;
        first_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clip test uses the widened sum so wrapped coordinates never plot.
  always_comb begin
    s0_valid = (state_q == ERASE)
            || (state_q == DRAW);
    s0_draw  = state_q == DRAW;
    base_x   = s0_draw ? new_x_q : last_x_q;
    base_y   = s0_draw ? new_y_q : last_y_q;
    px       = {1'b0, base_x} + 9'(col_q);
    py       = {1'b0, base_y} + 8'(row_q);
    rom_addr = '0;
    if (s0_draw) begin
      rom_addr = ADDR_W'(row_q)
               * ADDR_W'(SPRITE_W)
               + ADDR_W'(col_q);
    end
    s1_valid_d = s0_valid;
    s1_draw_d  = s0_draw;
    s1_x_d     = px[7:0];
    s1_y_d     = py[6:0];
    s1_in_d    = (px < 9'(SCREEN_W))
              && (py < 8'(SCREEN_H));
  end

  assign romAddr = rom_addr;
  assign oX      = s1_x_q;
  assign oY      = s1_y_q;
  assign oColour = !s1_valid_q ? 3'b000
                 : s1_draw_q ? romData
                 : BG_COLOUR;
  assign oPlot   = s1_valid_q && s1_in_q
                && !(s1_draw_q
                     && romData == TRANSPARENT);
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Randomised bench for sprite_renderer against a
// per-cycle expectation queue built from sprite rules.
module tb_sprite_renderer;

  localparam int W = 10;
  localparam int H = 11;
  localparam int N = W * H;

  logic       CLOCK;
  logic       Reset;
  logic [7:0] vgaX;
  logic [6:0] vgaY;
  logic [6:0] romAddr;
  logic [2:0] romData;
  logic [7:0] oX;
  logic [6:0] oY;
  logic [2:0] oColour;
  logic       oPlot;
  logic       busy;
  logic       done;

  sprite_renderer dut (
    .CLOCK   (CLOCK),
    .Reset   (Reset),
    .vgaX    (vgaX),
    .vgaY    (vgaY),
    .romAddr (romAddr),
    .romData (romData),
    .oX      (oX),
    .oY      (oY),
    .oColour (oColour),
    .oPlot   (oPlot),
    .busy    (busy),
    .done    (done)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  logic [2:0] rom [0:127];
  always @(posedge CLOCK) romData <= rom[romAddr];

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } rec_t;

  rec_t       q[$];
  logic       armed;
  logic       m_first;
  logic [7:0] m_lx;
  logic [6:0] m_ly;

  int m_checks, m_pass;
  int t_checks, t_pass;
  int cyc, n_plot, n_busy, n_done;
  int pc[8];
  logic prev_busy, seen_plot;
  int rise_cyc, fplot_cyc, done_cyc;

  // Expected outputs for every cycle after the trigger edge.
  task automatic build();
    int p, b, k, j, col, row, x9, y9;
    logic er;
    logic [2:0] c;
    rec_t r;
    p = m_first ? N : 2 * N;
    b = p + 1;
    for (int cc = 1; cc <= b + 1; cc++) begin
      r = '0;
      r.busy = (cc <= b);
      r.done = (cc == b + 1);
      k = cc - 2;
      if (k >= 0 && k < p) begin
        er = !m_first && k < N;
        j = (er || m_first) ? k : k - N;
        col = j % W;
        row = j / W;
        x9 = (er ? int'(m_lx) : int'(vgaX)) + col;
        y9 = (er ? int'(m_ly) : int'(vgaY)) + row;
        c = er ? 3'b011 : rom[j];
        r.plot = x9 < 160 && y9 < 120
              && (er || c != 3'b111);
        r.x = 8'(x9);
        r.y = 7'(y9);
        r.c = c;
      end
      q.push_back(r);
    end
    m_lx = vgaX;
    m_ly = vgaY;
    m_first = 1'b0;
  endtask

  initial begin
    m_checks = 0; m_pass = 0;
    cyc = 0; n_plot = 0; n_busy = 0; n_done = 0;
    for (int i = 0; i < 8; i++) pc[i] = 0;
    prev_busy = 0; seen_plot = 0;
    rise_cyc = 0; fplot_cyc = 0; done_cyc = 0;
    m_first = 1; m_lx = 0; m_ly = 0;
  end

  always @(negedge CLOCK) begin
    rec_t e;
    logic ok;
    if (armed) begin
      e = (q.size() != 0) ? q.pop_front() : '0;
      ok = busy === e.busy && done === e.done
        && oPlot === e.plot
        && (!e.plot || (oX === e.x && oY === e.y
                        && oColour === e.c));
      m_checks++;
      if (ok) m_pass++;
      else $display(
        "FAIL cycle %0d b/d/p/x/y/c got %b/%b/%b/%0d/%0d/%0d want %b/%b/%b/%0d/%0d/%0d",
        cyc, busy, done, oPlot, oX, oY, oColour,
        e.busy, e.done, e.plot, e.x, e.y, e.c);
      cyc++;
      if (oPlot === 1'b1) begin
        n_plot++;
        pc[oColour]++;
        if (!seen_plot) fplot_cyc = cyc;
        seen_plot = 1;
      end
      if (busy === 1'b1) n_busy++;
      if (busy === 1'b1 && !prev_busy) begin
        rise_cyc = cyc;
        seen_plot = 0;
      end
      if (done === 1'b1) begin
        n_done++;
        done_cyc = cyc;
      end
      prev_busy = busy;
      if (Reset) begin
        q.delete();
        m_first = 1;
        m_lx = 0;
        m_ly = 0;
      end else if (q.size() == 0
          && (m_first || vgaX != m_lx || vgaY != m_ly)) begin
        build();
      end
    end
  end

  int s_plot, s_busy, s_done;
  int s_pc[8];

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK);
    #2;
  endtask

  task automatic snap();
    s_plot = n_plot;
    s_busy = n_busy;
    s_done = n_done;
    s_pc = pc;
  endtask

  task automatic tcheck(input string nm,
                        input int got, input int want);
    t_checks++;
    if (got == want) t_pass++;
    else $display("FAIL %s: got %0d want %0d",
                  nm, got, want);
  endtask

  task automatic fill_rom(input logic [2:0] v);
    for (int i = 0; i < 128; i++) rom[i] = v;
  endtask

  initial begin
    t_checks = 0; t_pass = 0;
    armed = 0;
    Reset = 1;
    vgaX = 8'd0;
    vgaY = 7'd109;
    fill_rom(3'b100);
    step(3);
    armed = 1;
    @(negedge CLOCK);
    tcheck("rst_ox", int'(oX), 0);
    tcheck("rst_oy", int'(oY), 0);
    tcheck("rst_col", int'(oColour), 0);
    tcheck("rst_plot", int'(oPlot), 0);
    tcheck("rst_busy", int'(busy), 0);
    tcheck("rst_done", int'(done), 0);
    tcheck("rst_addr", int'(romAddr), 0);
    @(posedge CLOCK);
    #2;

    Reset = 0;
    snap();
    step(130);
    tcheck("t1_plots", n_plot - s_plot, 110);
    tcheck("t1_col4", pc[4] - s_pc[4], 110);
    tcheck("t1_erase", pc[3] - s_pc[3], 0);
    tcheck("t1_busy", n_busy - s_busy, 111);
    tcheck("t1_dones", n_done - s_done, 1);
    tcheck("t1_done_lat", done_cyc - rise_cyc, 111);
    tcheck("t1_plot_lat", fplot_cyc - rise_cyc, 1);

    vgaX = 8'd1;
    snap();
    step(240);
    tcheck("t2_plots", n_plot - s_plot, 220);
    tcheck("t2_erase", pc[3] - s_pc[3], 110);
    tcheck("t2_draw", pc[4] - s_pc[4], 110);
    tcheck("t2_dones", n_done - s_done, 1);
    tcheck("t2_done_lat", done_cyc - rise_cyc, 221);
    tcheck("t2_plot_lat", fplot_cyc - rise_cyc, 1);

    fill_rom(3'b010);
    rom[0] = 3'b111;
    rom[109] = 3'b111;
    vgaX = 8'd20;
    vgaY = 7'd30;
    snap();
    step(240);
    tcheck("t3_plots", n_plot - s_plot, 218);
    tcheck("t3_draw", pc[2] - s_pc[2], 108);

    Reset = 1;
    vgaX = 8'd155;
    vgaY = 7'd115;
    fill_rom(3'b100);
    step(2);
    Reset = 0;
    snap();
    step(130);
    tcheck("t4_plots", n_plot - s_plot, 25);
    tcheck("t4_busy", n_busy - s_busy, 111);

    snap();
    vgaX = 8'd5;
    vgaY = 7'd50;
    step(1);
    vgaX = 8'd6;
    step(3);
    vgaX = 8'd7;
    step(500);
    tcheck("t5_dones", n_done - s_done, 2);
    tcheck("t5_plots", n_plot - s_plot, 355);

    vgaX = 8'd30;
    vgaY = 7'd40;
    step(1);
    step(40);
    Reset = 1;
    step(1);
    @(negedge CLOCK);
    tcheck("t6_plot", int'(oPlot), 0);
    tcheck("t6_busy", int'(busy), 0);
    @(posedge CLOCK);
    #2;
    Reset = 0;
    snap();
    step(130);
    tcheck("t6_plots", n_plot - s_plot, 110);
    tcheck("t6_dones", n_done - s_done, 1);

    for (int i = 0; i < 128; i++)
      rom[i] = 3'($urandom_range(0, 7));
    for (int it = 0; it < 40; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        Reset = 1;
        step($urandom_range(1, 3));
        Reset = 0;
      end else if (r != 1) begin
        vgaX = 8'($urandom_range(0, 255));
        vgaY = 7'($urandom_range(0, 127));
      end
      step($urandom_range(1, 300));
    end
    step(500);

    $display("%0d/%0d checks passed",
             m_pass + t_pass, m_checks + t_checks);
    $finish;
  end

endmodule
